// File: rtl/plot_sink.sv
// Pixel-plot responder: 4-entry request FIFO, one-cycle write stage into a
// WIDTH x HEIGHT x 3-bit framebuffer, registered read port. Optional counters: PLOT_SINK_STATS_EN.
module plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       plot_valid,
  output logic       plot_ready,
  input  logic [7:0] plot_x,
  input  logic [6:0] plot_y,
  input  logic [2:0] plot_colour,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic [2:0] rd_data,
  output logic       rd_valid,
  output logic       frame_done,
  input  logic       clear_done,
  output logic       busy
`ifdef PLOT_SINK_STATS_EN
  ,
  output logic [14:0] wr_count,
  output logic [15:0] drop_count
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int AW   = 15;
  localparam int NPIX = WIDTH * HEIGHT;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_t;

  function automatic logic in_range(input logic [7:0] x, input logic [6:0] y);
    return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [7:0] x, input logic [6:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  plot_t          fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop;

  plot_t          wr_entry_q;
  logic           wr_valid_q;
  logic           wr_commit, wr_drop, wr_last;
  logic [AW-1:0]  wr_addr;

  logic [2:0]     ram [NPIX];
  logic [2:0]     rd_data_q;
  logic           rd_valid_q, frame_done_q;

  assign plot_ready = (count_q < CW'(DEPTH));
  assign push       = plot_valid && plot_ready;
  // The FIFO drains unconditionally; the write stage never stalls.
  assign pop        = (count_q != '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Writes landing on a reset edge are suppressed so in-flight requests never reach RAM.
  assign wr_commit = wr_valid_q && in_range(wr_entry_q.x, wr_entry_q.y) && !rst;
  assign wr_drop   = wr_valid_q && !in_range(wr_entry_q.x, wr_entry_q.y);
  assign wr_addr   = addr_of(wr_entry_q.x, wr_entry_q.y);
  assign wr_last   = wr_commit && (int'(wr_entry_q.x) == WIDTH - 1)
                               && (int'(wr_entry_q.y) == HEIGHT - 1);

  // NOTE: storage arrays (FIFO slots, framebuffer) carry no reset; validity is tracked by the pointers/flags.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{x: plot_x, y: plot_y, colour: plot_colour};
    if (pop)  wr_entry_q         <= fifo_mem[rd_ptr_q];
    if (wr_commit) ram[wr_addr]  <= wr_entry_q.colour;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_valid_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_valid_q <= pop;
      rd_valid_q <= rd_en;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      // Same-cycle read of an address being written sees the old word.
      if (rd_en) rd_data_q <= in_range(rd_x, rd_y) ? ram[addr_of(rd_x, rd_y)] : 3'd0;
      if (wr_last)         frame_done_q <= 1'b1;
      else if (clear_done) frame_done_q <= 1'b0;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (count_q != '0) | wr_valid_q;

`ifdef PLOT_SINK_STATS_EN
  logic [14:0] wr_count_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_done) begin
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      if (wr_commit && (wr_count_q != '1))  wr_count_q   <= wr_count_q + 15'd1;
      if (wr_drop && (drop_count_q != '1))  drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: directed scenarios plus randomized plots/reads
// compared against a pixel-array model of the framebuffer.
module tb_plot_sink;

  localparam int W = 160;
  localparam int H = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       plot_valid = 1'b0;
  logic       plot_ready;
  logic [7:0] plot_x = '0;
  logic [6:0] plot_y = '0;
  logic [2:0] plot_colour = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_x = '0;
  logic [6:0] rd_y = '0;
  logic [2:0] rd_data;
  logic       rd_valid;
  logic       frame_done;
  logic       clear_done = 1'b0;
  logic       busy;
`ifdef PLOT_SINK_STATS_EN
  logic [14:0] wr_count;
  logic [15:0] drop_count;
`endif

  plot_sink #(.WIDTH(W), .HEIGHT(H), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_done(frame_done), .clear_done(clear_done), .busy(busy)
`ifdef PLOT_SINK_STATS_EN
    , .wr_count(wr_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the framebuffer should hold, and which pixels are known.
  logic [2:0] fb_model [W*H];
  bit         known    [W*H];
  int         exp_wr   = 0;
  int         exp_drop = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(input int x, input int y, input int c);
    if (x < W && y < H) begin
      fb_model[y*W + x] = 3'(c);
      known[y*W + x]    = 1'b1;
      exp_wr++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic plot(input int x, input int y, input int c);
    int n;
    plot_valid  = 1'b1;
    plot_x      = 8'(x);
    plot_y      = 7'(y);
    plot_colour = 3'(c);
    n = 0;
    while (!plot_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!plot_ready) begin
      errors++;
      $display("FAIL plot_accept (%0d,%0d): ready=%b required 1", x, y, plot_ready);
    end
    step();
    plot_valid = 1'b0;
    model_accept(x, y, c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic read_px(input int x, input int y, output logic [2:0] d, output logic v);
    rd_en = 1'b1;
    rd_x  = 8'(x);
    rd_y  = 7'(y);
    step();
    d = rd_data;
    v = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    exp_wr   = 0;
    exp_drop = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (plot_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b frame_done=%b required 1 0 0", plot_ready, busy, frame_done);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 3'd0) begin
      errors++;
      $display("FAIL reset_read: rd_valid=%b rd_data=%0d required 0 0", rd_valid, rd_data);
    end
`ifdef PLOT_SINK_STATS_EN
    checks++;
    if (wr_count !== 15'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: wr=%0d drop=%0d required 0 0", wr_count, drop_count);
    end
`endif
    exp_wr   = 0;
    exp_drop = 0;
  endtask

  task automatic test_single_plot();
    logic [2:0] d;
    logic v;
    plot(3, 2, 5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_set: busy=%b required 1", busy);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_clear: busy=%b required 0", busy);
    end
    step();
    read_px(3, 2, d, v);
    checks++;
    if (v !== 1'b1 || d !== 3'd5) begin
      errors++;
      $display("FAIL single_read: valid=%b data=%0d required 1 5", v, d);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_rd_pulse: rd_valid=%b required 0", rd_valid);
    end
  endtask

  task automatic test_stream();
    int drops;
    logic [2:0] d;
    logic v;
    drops = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        plot_valid  = 1'b1;
        plot_x      = 8'(x);
        plot_y      = 7'(y);
        plot_colour = 3'(x % 8);
        if (!plot_ready) drops++;
        step();
        model_accept(x, y, x % 8);
      end
    end
    plot_valid = 1'b0;
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL stream_ready: ready low on %0d cycles required 0", drops);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_early0: frame_done=%b required 0", frame_done);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_early1: frame_done=%b required 0", frame_done);
    end
    step();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL stream_done_rise: frame_done=%b required 1", frame_done);
    end
    drain();
    read_px(157, 40, d, v);
    checks++;
    if (v !== 1'b1 || d !== 3'd5) begin
      errors++;
      $display("FAIL stream_read_157_40: valid=%b data=%0d required 1 5", v, d);
    end
    read_px(159, 119, d, v);
    checks++;
    if (v !== 1'b1 || d !== 3'd7) begin
      errors++;
      $display("FAIL stream_read_last: valid=%b data=%0d required 1 7", v, d);
    end
  endtask

  task automatic test_backpressure();
    int xs [5] = '{20, 21, 22, 20, 23};
    int cs [5] = '{1, 2, 3, 4, 6};
    int n;
    logic [2:0] d;
    logic v;
    force dut.pop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      plot_valid  = 1'b1;
      plot_x      = 8'(xs[k]);
      plot_y      = 7'd5;
      plot_colour = 3'(cs[k]);
      checks++;
      if (plot_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_%0d: ready=%b required 1", k, plot_ready);
      end
      step();
      model_accept(xs[k], 5, cs[k]);
    end
    plot_x      = 8'(xs[4]);
    plot_colour = 3'(cs[4]);
    checks++;
    if (plot_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: ready=%b required 0", plot_ready);
    end
    step();
    step();
    checks++;
    if (plot_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_held: ready=%b required 0", plot_ready);
    end
    release dut.pop;
    n = 0;
    while (!plot_ready && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (!plot_ready) begin
      errors++;
      $display("FAIL bp_resume: ready=%b required 1", plot_ready);
    end
    step();
    plot_valid = 1'b0;
    model_accept(xs[4], 5, cs[4]);
    drain();
    for (int k = 0; k < 4; k++) begin
      read_px(20 + k, 5, d, v);
      checks++;
      if (v !== 1'b1 || d !== fb_model[5*W + 20 + k]) begin
        errors++;
        $display("FAIL bp_read_%0d: valid=%b data=%0d required 1 %0d", 20 + k, v, d, fb_model[5*W + 20 + k]);
      end
    end
    read_px(20, 5, d, v);
    checks++;
    if (d !== 3'd4) begin
      errors++;
      $display("FAIL bp_order: data=%0d required 4", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] d;
    logic v;
    plot(0, 0, 3);
    drain();
    pulse_clear();
    plot(160, 0, 6);
    plot(0, 120, 6);
    drain();
    read_px(0, 0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 3'd3) begin
      errors++;
      $display("FAIL oor_ram_untouched: valid=%b data=%0d required 1 3", v, d);
    end
    read_px(160, 0, d, v);
    checks++;
    if (v !== 1'b1 || d !== 3'd0) begin
      errors++;
      $display("FAIL oor_read: valid=%b data=%0d required 1 0", v, d);
    end
`ifdef PLOT_SINK_STATS_EN
    checks++;
    if (drop_count !== 16'd2 || wr_count !== 15'd0) begin
      errors++;
      $display("FAIL oor_stats: wr=%0d drop=%0d required 0 2", wr_count, drop_count);
    end
`endif
  endtask

  task automatic test_read_before_write();
    logic [2:0] d;
    logic v;
    plot(10, 10, 2);
    drain();
    plot_valid  = 1'b1;
    plot_x      = 8'd10;
    plot_y      = 7'd10;
    plot_colour = 3'd7;
    step();
    plot_valid = 1'b0;
    step();
    rd_en = 1'b1;
    rd_x  = 8'd10;
    rd_y  = 7'd10;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 3'd2) begin
      errors++;
      $display("FAIL rbw_old: valid=%b data=%0d required 1 2", rd_valid, rd_data);
    end
    model_accept(10, 10, 7);
    read_px(10, 10, d, v);
    checks++;
    if (v !== 1'b1 || d !== 3'd7) begin
      errors++;
      $display("FAIL rbw_new: valid=%b data=%0d required 1 7", v, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] d;
    logic v;
    for (int k = 0; k < 3; k++) plot(50 + k, 50, 1);
    plot(159, 119, 7);
    drain();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_done_set: frame_done=%b required 1", frame_done);
    end
    plot_valid  = 1'b1;
    plot_y      = 7'd50;
    plot_colour = 3'd6;
    plot_x      = 8'd50;
    step();
    plot_x      = 8'd51;
    step();
    plot_x      = 8'd52;
    rst         = 1'b1;
    step();
    rst         = 1'b0;
    plot_valid  = 1'b0;
    exp_wr   = 0;
    exp_drop = 0;
    checks++;
    if (plot_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: ready=%b busy=%b frame_done=%b required 1 0 0", plot_ready, busy, frame_done);
    end
    step();
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      read_px(50 + k, 50, d, v);
      checks++;
      if (v !== 1'b1 || d !== 3'd1) begin
        errors++;
        $display("FAIL mid_discard_%0d: valid=%b data=%0d required 1 1", 50 + k, v, d);
      end
    end
    plot(159, 119, 7);
    drain();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: frame_done=%b required 0", frame_done);
    end
    // Commit of the last pixel and clear_done on the same edge: set wins.
    plot(159, 119, 7);
    step();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: frame_done=%b required 1", frame_done);
    end
  endtask

  task automatic test_random();
    int x, y, c;
    logic [2:0] d;
    logic v;
    bit acc;
    pulse_clear();
    for (int i = 0; i < 400; i++) begin
      x = int'($urandom_range(0, 170));
      y = int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 7));
      plot_valid  = ($urandom_range(0, 9) < 7);
      plot_x      = 8'(x);
      plot_y      = 7'(y);
      plot_colour = 3'(c);
      acc = plot_valid && plot_ready;
      step();
      if (acc) model_accept(x, y, c);
    end
    plot_valid = 1'b0;
    drain();
`ifdef PLOT_SINK_STATS_EN
    checks++;
    if (int'(wr_count) != exp_wr || int'(drop_count) != exp_drop) begin
      errors++;
      $display("FAIL rand_stats: wr=%0d drop=%0d required %0d %0d", wr_count, drop_count, exp_wr, exp_drop);
    end
`endif
    for (int i = 0; i < 60; i++) begin
      x = int'($urandom_range(0, 165));
      y = int'($urandom_range(0, 125));
      read_px(x, y, d, v);
      if (x >= W || y >= H) begin
        checks++;
        if (v !== 1'b1 || d !== 3'd0) begin
          errors++;
          $display("FAIL rand_oor_read (%0d,%0d): valid=%b data=%0d required 1 0", x, y, v, d);
        end
      end else if (known[y*W + x]) begin
        checks++;
        if (v !== 1'b1 || d !== fb_model[y*W + x]) begin
          errors++;
          $display("FAIL rand_read (%0d,%0d): valid=%b data=%0d required 1 %0d", x, y, v, d, fb_model[y*W + x]);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_plot();
    test_stream();
    test_backpressure();
    test_out_of_range();
    test_read_before_write();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
